// File: rtl/temporizador_jogo_pkg.sv
// Shared definitions for the game timer and the control unit's top level.
//   - estado_t: FSM state encoding, which is also the 7-segment debug code.
//   - DB_INVALIDO: debug code shown for any state code outside estado_t.
//   - *_PADRAO: default timing constants (50 MHz board clock).
package temporizador_jogo_pkg;

    typedef enum logic [3:0] {
        PARADO   = 4'h0,
        CONTANDO = 4'h1,
        ESGOTADO = 4'hF
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'hD;

    localparam int TICKS_PER_SEC_PADRAO = 50_000_000;
    localparam int TEMPO_INICIAL_PADRAO = 60;
    localparam int PENALIDADE_PADRAO    = 5;
    localparam int LIMITE_ALERTA_PADRAO = 10;
    localparam int W_PADRAO             = 8;

endpackage

// File: rtl/temporizador_jogo_divisor_segundo.sv
// Seconds prescaler.
//   clock, reset : board clock, asynchronous active-high reset
//   zera         : synchronous clear of the cycle counter (wins over conta)
//   conta        : advance the counter by one this cycle
//   tick         : high in the cycle where the counter wraps from
//                  TICKS_PER_SEC-1 to 0 (so the owner can act on that edge)
module divisor_segundo #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic tick
);

    // Keep at least one bit so TICKS_PER_SEC = 1 still elaborates.
    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] contagem;

    assign tick = conta && !zera && (contagem == ULTIMO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            if (contagem == ULTIMO) begin
                contagem <= '0;
            end else begin
                contagem <= contagem + 1'b1;
            end
        end
    end

endmodule

// File: rtl/temporizador_jogo.sv
// Game countdown timer.
//   clock, reset : board clock, asynchronous active-high reset
//   zeraT        : reload tempo and clear the prescaler (beats everything but reset)
//   contaT       : level; while high the prescaler runs
//   decresceT    : one penalty per high cycle
//   fimT         : high only in ESGOTADO (time expired)
//   tempo        : remaining seconds
//   pulso_seg    : one-cycle pulse alongside each prescaler-driven decrement
//   alerta       : tempo <= LIMITE_ALERTA
//   db_estado    : state code for the debug display
//
// Control-unit interface: there is no handshake. zeraT/contaT/decresceT are
// sampled on every rising edge; fimT is a registered level the control unit
// polls, and stays high until zeraT or reset.
module temporizador_jogo
    import temporizador_jogo_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_PADRAO,
    parameter int TEMPO_INICIAL = TEMPO_INICIAL_PADRAO,
    parameter int PENALIDADE    = PENALIDADE_PADRAO,
    parameter int LIMITE_ALERTA = LIMITE_ALERTA_PADRAO,
    parameter int W             = W_PADRAO
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zeraT,
    input  logic         contaT,
    input  logic         decresceT,
    output logic         fimT,
    output logic [W-1:0] tempo,
    output logic         pulso_seg,
    output logic         alerta,
    output logic [3:0]   db_estado
);

    localparam logic [W-1:0] TEMPO_RECARGA = W'(TEMPO_INICIAL);
    localparam logic [W-1:0] LIMITE        = W'(LIMITE_ALERTA);
    localparam logic [W:0]   PEN_EXT       = (W+1)'(PENALIDADE);

    estado_t      estado;
    logic         ativo;
    logic         contaDiv;
    logic         tick;
    logic [W:0]   subtraendo;
    logic [W:0]   diferenca;
    logic [W-1:0] tempoProx;

    // The prescaler only runs while the game is live; in ESGOTADO it freezes.
    assign ativo    = (estado == PARADO) || (estado == CONTANDO);
    assign contaDiv = contaT && ativo;

    divisor_segundo #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_divisor (
        .clock(clock),
        .reset(reset),
        .zera (zeraT),
        .conta(contaDiv),
        .tick (tick)
    );

    // One W+1-bit subtraction covers tick, penalty or both; a set top bit
    // means the result went below zero, so clamp.
    always_comb begin
        subtraendo = '0;
        if (tick) begin
            subtraendo = subtraendo + 1'b1;
        end
        if (decresceT && ativo) begin
            subtraendo = subtraendo + PEN_EXT;
        end
        diferenca = {1'b0, tempo} - subtraendo;
        tempoProx = diferenca[W] ? '0 : diferenca[W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= PARADO;
            tempo     <= TEMPO_RECARGA;
            fimT      <= 1'b0;
            pulso_seg <= 1'b0;
        end else if (zeraT) begin
            estado    <= PARADO;
            tempo     <= TEMPO_RECARGA;
            fimT      <= 1'b0;
            pulso_seg <= 1'b0;
        end else begin
            case (estado)
                PARADO, CONTANDO: begin
                    tempo     <= tempoProx;
                    pulso_seg <= tick;
                    // tempo == 0 catches a zero start value.
                    if ((tempoProx == '0) || (tempo == '0)) begin
                        estado <= ESGOTADO;
                        fimT   <= 1'b1;
                    end else begin
                        estado <= contaT ? CONTANDO : PARADO;
                        fimT   <= 1'b0;
                    end
                end
                ESGOTADO: begin
                    tempo     <= '0;
                    fimT      <= 1'b1;
                    pulso_seg <= 1'b0;
                end
                default: begin
                    estado    <= PARADO;
                    fimT      <= 1'b0;
                    pulso_seg <= 1'b0;
                end
            endcase
        end
    end

    assign alerta = (tempo <= LIMITE);

    always_comb begin
        case (estado)
            PARADO:   db_estado = 4'h0;
            CONTANDO: db_estado = 4'h1;
            ESGOTADO: db_estado = 4'hF;
            default:  db_estado = DB_INVALIDO;
        endcase
    end

endmodule

// File: tb/tb_temporizador_jogo.sv
// Bench for temporizador_jogo with TICKS_PER_SEC=4, TEMPO_INICIAL=10,
// PENALIDADE=3, LIMITE_ALERTA=4.
module tb_temporizador_jogo;

    logic       clock;
    logic       reset;
    logic       zeraT;
    logic       contaT;
    logic       decresceT;
    logic       fimT;
    logic [7:0] tempo;
    logic       pulso_seg;
    logic       alerta;
    logic [3:0] db_estado;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic       zera;
        logic       conta;
        logic       decresce;
        logic [7:0] expTempo;
        logic       expPulso;
        logic       expFim;
        logic       expAlerta;
        logic [3:0] expDb;
    } vetor_t;

    vetor_t vetores[$];

    temporizador_jogo #(
        .TICKS_PER_SEC(4),
        .TEMPO_INICIAL(10),
        .PENALIDADE   (3),
        .LIMITE_ALERTA(4),
        .W            (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .zeraT    (zeraT),
        .contaT   (contaT),
        .decresceT(decresceT),
        .fimT     (fimT),
        .tempo    (tempo),
        .pulso_seg(pulso_seg),
        .alerta   (alerta),
        .db_estado(db_estado)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver: apply inputs, take one rising edge, settle 1 time unit
    task automatic ciclo(input logic z, input logic c, input logic d);
        zeraT     = z;
        contaT    = c;
        decresceT = d;
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        nChecks++;
        if (atual === esperado) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic verifica_saidas(input string nome, input logic [7:0] t, input logic p,
                                   input logic f, input logic a, input logic [3:0] db);
        verifica({nome, " tempo"},     32'(tempo),     32'(t));
        verifica({nome, " pulso_seg"}, 32'(pulso_seg), 32'(p));
        verifica({nome, " fimT"},      32'(fimT),      32'(f));
        verifica({nome, " alerta"},    32'(alerta),    32'(a));
        verifica({nome, " db_estado"}, 32'(db_estado), 32'(db));
    endtask

    task automatic add(input logic z, input logic c, input logic d, input logic [7:0] t,
                       input logic p, input logic f, input logic a, input logic [3:0] db);
        vetor_t v;
        v.zera = z; v.conta = c; v.decresce = d;
        v.expTempo = t; v.expPulso = p; v.expFim = f; v.expAlerta = a; v.expDb = db;
        vetores.push_back(v);
    endtask

    initial begin
        // Table: free count, pause/resume, penalty run to expiry.
        for (int i = 0; i < 3; i++) add(0, 1, 0, 10, 0, 0, 0, 4'h1);
        add(0, 1, 0, 9, 1, 0, 0, 4'h1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 9, 0, 0, 0, 4'h1);
        add(0, 1, 0, 8, 1, 0, 0, 4'h1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 8, 0, 0, 0, 4'h1);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 8, 0, 0, 0, 4'h0);
        add(0, 1, 0, 7, 1, 0, 0, 4'h1);   // resumes: wraps after one cycle
        add(1, 0, 0, 10, 0, 0, 0, 4'h0);
        add(0, 0, 1, 7, 0, 0, 0, 4'h0);
        add(0, 0, 1, 4, 0, 0, 1, 4'h0);
        add(0, 0, 1, 1, 0, 0, 1, 4'h0);
        add(0, 0, 1, 0, 0, 1, 1, 4'hF);
        add(0, 0, 0, 0, 0, 1, 1, 4'hF);

        reset = 1'b1; zeraT = 1'b0; contaT = 1'b0; decresceT = 1'b0;
        #2;
        verifica_saidas("reset", 10, 0, 0, 0, 4'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (vetores[i]) begin
            ciclo(vetores[i].zera, vetores[i].conta, vetores[i].decresce);
            verifica_saidas($sformatf("v%0d", i), vetores[i].expTempo, vetores[i].expPulso,
                            vetores[i].expFim, vetores[i].expAlerta, vetores[i].expDb);
        end

        // ESGOTADO ignores contaT and decresceT.
        for (int i = 0; i < 20; i++) begin
            ciclo(0, 1, 1);
            verifica($sformatf("esg%0d tempo", i), 32'(tempo), 32'd0);
            verifica($sformatf("esg%0d fimT", i),  32'(fimT),  32'd1);
            verifica($sformatf("esg%0d pulso", i), 32'(pulso_seg), 32'd0);
        end
        verifica("esg db_estado", 32'(db_estado), 32'hF);

        // zeraT beats contaT and decresceT in the same cycle.
        ciclo(1, 1, 1);
        verifica_saidas("zera", 10, 0, 0, 0, 4'h0);

        // Tick and penalty together at tempo = 5.
        ciclo(0, 0, 1);
        verifica("pen7 tempo", 32'(tempo), 32'd7);
        for (int i = 0; i < 8; i++) ciclo(0, 1, 0);
        verifica("t5 tempo", 32'(tempo), 32'd5);
        for (int i = 0; i < 3; i++) ciclo(0, 1, 0);
        verifica("pre tick tempo", 32'(tempo), 32'd5);
        ciclo(0, 1, 1);
        verifica_saidas("tick+pen", 1, 1, 0, 1, 4'h1);
        ciclo(0, 0, 0);
        verifica_saidas("after tick+pen", 1, 0, 0, 1, 4'h0);

        // Penalty larger than tempo saturates at 0 and expires.
        ciclo(0, 0, 1);
        verifica_saidas("saturate", 0, 0, 1, 1, 4'hF);

        // Asynchronous reset at tempo = 6, prescaler = 2.
        ciclo(1, 0, 0);
        for (int i = 0; i < 18; i++) ciclo(0, 1, 0);
        verifica_saidas("pre reset", 6, 0, 0, 0, 4'h1);
        #3;
        contaT = 1'b0;
        reset  = 1'b1;
        #1;
        verifica_saidas("async reset", 10, 0, 0, 0, 4'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        // Prescaler must restart from 0: first wrap on the fourth counting cycle.
        for (int i = 0; i < 3; i++) begin
            ciclo(0, 1, 0);
            verifica($sformatf("post reset %0d tempo", i), 32'(tempo), 32'd10);
            verifica($sformatf("post reset %0d pulso", i), 32'(pulso_seg), 32'd0);
        end
        ciclo(0, 1, 0);
        verifica_saidas("post reset tick", 9, 1, 0, 0, 4'h1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
